puf_crp_controller: RTL
=======================

# puf_crp_controller

Parametrised challenge–response pair (CRP) controller for the PUF lab datapath. It generates a sequence of challenges from an LFSR seed and applies each one to the PUF core. Every challenge is evaluated NUM_EVAL times, the responses are majority-voted per bit, and each voted CRP, with a per-bit instability mask, is streamed out over a valid/ready port. It sits between the board-level front end (switches/UART loader) and the PUF core, replacing the fixed 64-bit single-shot controller.

## Interface
- CH_W, 64, challenge width in bits
- RESP_W, 64, response width in bits
- NUM_EVAL, 5, evaluations per challenge; must be odd and ≥1
- SETTLE, 16, cycles the challenge is held before puf_en is asserted; must be ≥1
- TAP_MASK, 64'hD800_0000_0000_0000, LFSR feedback mask (CH_W bits)

- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- seed  in  CH_W  first challenge; latched on accepted start
- num_crp  in  16  number of CRPs in the run; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- puf_challenge  out  CH_W  challenge driven to the PUF core
- puf_en  out  1  evaluation strobe to the PUF core
- puf_resp  in  RESP_W  PUF response, valid when puf_resp_valid
- puf_resp_valid  in  1  single-cycle response qualifier
- crp_valid  out  1  output CRP valid
- crp_ready  in  1  downstream accept
- crp_challenge  out  CH_W  challenge of the output CRP
- crp_response  out  RESP_W  majority-voted response
- crp_unstable  out  RESP_W  bit i set when the NUM_EVAL votes for bit i were not unanimous
- done  out  1  one-cycle pulse at end of run

## Operation
- FSM states: IDLE → SETTLE → EVAL → VOTE → OUT → (SETTLE | FINISH) → IDLE.
- IDLE: when start=1, latch seed and num_crp. If the latched seed is 0, replace it with CH_W'(1). If num_crp=0, go to FINISH. Otherwise go to SETTLE with crp_idx=0.
- SETTLE: drive puf_challenge, count SETTLE cycles, clear the vote counters and eval_idx, then go to EVAL.
- EVAL: puf_en=1 until puf_resp_valid=1. On each valid, add puf_resp[i] to the per-bit counter i and increment eval_idx. After NUM_EVAL responses go to VOTE. puf_resp_valid outside EVAL is ignored.
- Per-bit counters are $clog2(NUM_EVAL+1) bits wide. The counters cannot overflow.
- VOTE (1 cycle): response[i] = cnt[i] > NUM_EVAL/2; unstable[i] = cnt[i]≠0 && cnt[i]≠NUM_EVAL. Register both into the output regs, then go to OUT.
- OUT: crp_valid=1. crp_challenge, crp_response and crp_unstable hold stable until crp_ready=1.
- On handshake: advance the challenge to {c[CH_W-2:0], ^(c & TAP_MASK)} and increment crp_idx. If crp_idx+1 = num_crp go to FINISH, else go to SETTLE.
- FINISH: done=1 for one cycle, then go to IDLE.
- start while busy is ignored and is not queued.

## Timing
- Reset values: all outputs 0; FSM in IDLE; challenge reg 0; counters 0.
- Reset asserted mid-run aborts the run immediately. No done pulse is produced.
- busy rises 1 cycle after the start edge and falls in the cycle after the done pulse.
- puf_challenge is valid from the first SETTLE cycle. puf_en rises exactly SETTLE cycles later.
- First crp_valid appears SETTLE + (NUM_EVAL response waits) + 2 cycles after start, counting the VOTE and OUT register stages.
- crp_ready held high gives zero stall: the next SETTLE begins in the cycle after the handshake.
- puf_resp_valid in the same cycle that eval_idx reaches NUM_EVAL is counted; no further valids are counted.
- num_crp=0: done pulses 1 cycle after start, with busy high for that one cycle only.

## Structure
- Shared package puf_pkg holds:
  - the state enum (crp_state_t)
  - the LFSR step function lfsr_next(c, mask)
  - the default TAP_MASK constant
  - the vote-counter width function
- One sub-module, puf_majority_voter, holds the RESP_W per-bit counters, the clear/accumulate controls and the voted/unstable outputs. The FSM stays in the top level.

## Test plan
- Single run, NUM_EVAL=5, seed=64'h1, num_crp=1, PUF model returns 64'hA5A5…A5 on all evals → one CRP with challenge 64'h1, response 64'hA5…A5, unstable=0, then done.
- Noisy bit: bit 0 reads 1,1,0,1,0 across 5 evals → response[0]=1, unstable[0]=1. All other bits are stable.
- LFSR sequence: seed=64'h1, num_crp=4, crp_ready=1 → challenges 1, 2, 4, 8, then done. seed=0 yields the same sequence as seed=1.
- Backpressure: crp_ready low for 10 cycles in OUT → crp_valid and the output data are held unchanged, and no puf_en is issued.
- num_crp=0 → done one cycle after start; no crp_valid and no puf_en.
- rst pulsed during EVAL of CRP 2 → all outputs 0, no done. A subsequent start runs cleanly from the new seed.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF challenge-response pair controller.
package puf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StEval,
    StVote,
    StOut,
    StFinish
  } crp_state_t;

  // Widest challenge the LFSR helper supports; callers zero-extend and truncate.
  localparam int unsigned LfsrMaxW = 256;

  localparam logic [63:0] DefaultTapMask = 64'hD800_0000_0000_0000;

  // Counter width able to hold 0..num_eval inclusive.
  function automatic int unsigned vote_cnt_w(input int unsigned num_eval);
    return $clog2(num_eval + 1);
  endfunction

  // Shift left, feed the masked parity into bit 0. Truncating the result to the
  // caller's width yields {c[W-2:0], ^(c & mask)}.
  function automatic logic [LfsrMaxW-1:0] lfsr_next(input logic [LfsrMaxW-1:0] c,
                                                    input logic [LfsrMaxW-1:0] mask);
    return {c[LfsrMaxW-2:0], ^(c & mask)};
  endfunction

endpackage

// File: rtl/puf_majority_voter.sv
// Per-bit vote counters with majority and instability decode.
module puf_majority_voter
  import puf_pkg::*;
#(
  parameter int unsigned RESP_W   = 64,
  parameter int unsigned NUM_EVAL = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              acc,
  input  logic [RESP_W-1:0] resp,
  output logic [RESP_W-1:0] voted,
  output logic [RESP_W-1:0] unstable
);

  localparam int unsigned CntW = vote_cnt_w(NUM_EVAL);
  localparam logic [CntW-1:0] Half = CntW'(NUM_EVAL / 2);
  localparam logic [CntW-1:0] Full = CntW'(NUM_EVAL);

  logic [CntW-1:0] cnt_q [RESP_W];
  logic [CntW-1:0] cnt_d [RESP_W];

  // Clear wins over accumulate; otherwise add each response bit to its counter.
  always_comb begin
    for (int i = 0; i < RESP_W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (acc) begin
        cnt_d[i] = cnt_q[i] + CntW'(resp[i]);
      end
    end
  end

  // Counter storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RESP_W; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < RESP_W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Majority and non-unanimous decode.
  always_comb begin
    voted    = '0;
    unstable = '0;
    for (int i = 0; i < RESP_W; i++) begin
      voted[i]    = cnt_q[i] > Half;
      unstable[i] = (cnt_q[i] != '0) && (cnt_q[i] != Full);
    end
  end

endmodule

// File: rtl/puf_crp_controller.sv
// Challenge-response pair controller: LFSR challenges, repeated PUF evaluation,
// majority vote, and valid/ready streaming of voted CRPs.
module puf_crp_controller
  import puf_pkg::*;
#(
  parameter int unsigned     CH_W     = 64,
  parameter int unsigned     RESP_W   = 64,
  parameter int unsigned     NUM_EVAL = 5,
  parameter int unsigned     SETTLE   = 16,
  parameter logic [CH_W-1:0] TAP_MASK = CH_W'(DefaultTapMask)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   seed,
  input  logic [15:0]       num_crp,
  output logic              busy,
  output logic [CH_W-1:0]   puf_challenge,
  output logic              puf_en,
  input  logic [RESP_W-1:0] puf_resp,
  input  logic              puf_resp_valid,
  output logic              crp_valid,
  input  logic              crp_ready,
  output logic [CH_W-1:0]   crp_challenge,
  output logic [RESP_W-1:0] crp_response,
  output logic [RESP_W-1:0] crp_unstable,
  output logic              done
);

  localparam int unsigned EvalW   = vote_cnt_w(NUM_EVAL);
  localparam int unsigned SettleW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [EvalW-1:0]   EvalLast   = EvalW'(NUM_EVAL - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE - 1);

  crp_state_t         state_q, state_d;
  logic [CH_W-1:0]    chal_q, chal_d;
  logic [15:0]        num_q, num_d;
  logic [15:0]        idx_q, idx_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic [EvalW-1:0]   eval_q, eval_d;
  logic [RESP_W-1:0]  resp_q, resp_d;
  logic [RESP_W-1:0]  unst_q, unst_d;

  logic              vote_clr, vote_acc;
  logic [RESP_W-1:0] voted, unstable;
  logic [CH_W-1:0]   chal_step;

  assign chal_step = CH_W'(lfsr_next(LfsrMaxW'(chal_q), LfsrMaxW'(TAP_MASK)));

  puf_majority_voter #(
    .RESP_W  (RESP_W),
    .NUM_EVAL(NUM_EVAL)
  ) u_voter (
    .clk     (clk),
    .rst     (rst),
    .clr     (vote_clr),
    .acc     (vote_acc),
    .resp    (puf_resp),
    .voted   (voted),
    .unstable(unstable)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      chal_q   <= '0;
      num_q    <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      eval_q   <= '0;
      resp_q   <= '0;
      unst_q   <= '0;
    end else begin
      state_q  <= state_d;
      chal_q   <= chal_d;
      num_q    <= num_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      eval_q   <= eval_d;
      resp_q   <= resp_d;
      unst_q   <= unst_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    chal_d   = chal_q;
    num_d    = num_q;
    idx_d    = idx_q;
    settle_d = '0;
    eval_d   = eval_q;
    resp_d   = resp_q;
    unst_d   = unst_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // An all-zero seed would lock the LFSR at zero.
          chal_d  = (seed == '0) ? CH_W'(1) : seed;
          num_d   = num_crp;
          idx_d   = '0;
          state_d = (num_crp == '0) ? StFinish : StSettle;
        end
      end
      StSettle: begin
        settle_d = settle_q + SettleW'(1);
        eval_d   = '0;
        if (settle_q == SettleLast) begin
          settle_d = '0;
          state_d  = StEval;
        end
      end
      StEval: begin
        if (puf_resp_valid) begin
          eval_d = eval_q + EvalW'(1);
          if (eval_q == EvalLast) state_d = StVote;
        end
      end
      StVote: begin
        resp_d  = voted;
        unst_d  = unstable;
        state_d = StOut;
      end
      StOut: begin
        if (crp_ready) begin
          chal_d  = chal_step;
          idx_d   = idx_q + 16'd1;
          state_d = (idx_q + 16'd1 == num_q) ? StFinish : StSettle;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State-decoded outputs and voter controls.
  always_comb begin
    busy          = state_q != StIdle;
    puf_en        = state_q == StEval;
    crp_valid     = state_q == StOut;
    done          = state_q == StFinish;
    vote_clr      = state_q == StSettle;
    vote_acc      = (state_q == StEval) && puf_resp_valid;
    puf_challenge = chal_q;
    crp_challenge = chal_q;
    crp_response  = resp_q;
    crp_unstable  = unst_q;
  end

endmodule
